// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit. The execute stage is the master; the unit is the slave.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] tg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result1;
    logic [WIDTH-1:0] result2;
    logic             div_zero;

    modport master (
        output start, op, sr, tg,
        input  busy, done, result1, result2, div_zero
    );

    modport slave (
        input  start, op, sr, tg,
        output busy, done, result1, result2, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit for mult/multu/div/divu.
// Signed operations run on magnitudes and are sign-corrected in a single FIX
// cycle. Multiply is radix-2 shift-add and divide is restoring shift-subtract,
// both on one 2*WIDTH accumulator, one bit per cycle for WIDTH cycles.
// result1 = LO / quotient, result2 = HI / remainder.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    state_t             next_state;

    // Captured operation context.
    logic               is_div_q;
    logic               neg_q;      // product / quotient must be negated
    logic               rem_neg_q;  // remainder takes the dividend's sign
    logic [WIDTH-1:0]   opnd_q;     // multiplicand (mult) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc_q;      // mult: {partial HI, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]      cnt_q;

    // Architectural results, held until the next accepted start.
    logic [WIDTH-1:0]   result1_q;
    logic [WIDTH-1:0]   result2_q;
    logic               div_zero_q;

    // Operand preparation at acceptance time.
    logic               signed_op;
    logic               sr_neg;
    logic               tg_neg;
    logic               tg_zero;
    logic [WIDTH-1:0]   sr_mag;
    logic [WIDTH-1:0]   tg_mag;
    logic               last_iter;

    assign signed_op = ~bus.op[0];
    assign sr_neg    = signed_op & bus.sr[WIDTH-1];
    assign tg_neg    = signed_op & bus.tg[WIDTH-1];
    assign sr_mag    = sr_neg ? -bus.sr : bus.sr;
    assign tg_mag    = tg_neg ? -bus.tg : bus.tg;
    assign tg_zero   = (bus.tg == '0);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Iteration and sign-fix datapath.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   fix_r1;
    logic [WIDTH-1:0]   fix_r2;

    // One shift-add or restoring shift-subtract step, plus the sign-corrected results.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        step_next = acc_q;
        fix_r1    = '0;
        fix_r2    = '0;

        // Multiply: add multiplicand into HI when the multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod_fixed = neg_q ? -acc_q : acc_q;
        quo_raw    = acc_q[WIDTH-1:0];
        rem_raw    = acc_q[2*WIDTH-1:WIDTH];

        if (is_div_q) begin
            fix_r1 = neg_q ? -quo_raw : quo_raw;
            fix_r2 = rem_neg_q ? -rem_raw : rem_raw;
        end else begin
            fix_r1 = prod_fixed[WIDTH-1:0];
            fix_r2 = prod_fixed[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: divide by zero skips the iterations entirely.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = (bus.op[1] && tg_zero) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture operands on acceptance, iterate in CALC, publish results in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result1_q  <= '0;
            result2_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div_q   <= bus.op[1];
                        neg_q      <= sr_neg ^ tg_neg;
                        rem_neg_q  <= bus.op[1] & sr_neg;
                        cnt_q      <= '0;
                        div_zero_q <= 1'b0;
                        if (bus.op[1]) begin
                            opnd_q <= tg_mag;
                            acc_q  <= {{WIDTH{1'b0}}, sr_mag};
                        end else begin
                            opnd_q <= sr_mag;
                            acc_q  <= {{WIDTH{1'b0}}, tg_mag};
                        end
                        if (bus.op[1] && tg_zero) begin
                            result1_q  <= '1;
                            result2_q  <= bus.sr;
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    result1_q <= fix_r1;
                    result2_q <= fix_r2;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == CALC) || (state == FIX);
    assign bus.done     = (state == DONE);
    assign bus.result1  = result1_q;
    assign bus.result2  = result2_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a table of operations with hand-computed
// results, then hand-written sequences for ignored starts and mid-op reset.
module tb_muldiv_seq;

    localparam int WIDTH = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] sr;
        logic [31:0] tg;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a one-cycle start; returns at the first sample point after acceptance.
    task automatic start_op(input logic [1:0] op, input logic [31:0] sr, input logic [31:0] tg);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.sr    = sr;
        bus.tg    = tg;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sr    = ~sr;
        bus.tg    = tg ^ 32'h5A5A_5A5A;
    endtask

    // Bounded wait for done; lat counts cycles after the start cycle.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        int          done_cnt;
        logic [31:0] prev_r1;
        logic [31:0] prev_r2;

        vecs[0]  = '{"multu_small",   OP_MULTU, 32'h0000_0010, 32'h0000_0004, 32'h0000_0040, 32'h0000_0000, 1'b0};
        vecs[1]  = '{"mult_neg5x3",   OP_MULT,  32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{"mult_extreme",  OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0};
        vecs[4]  = '{"divu_16_3",     OP_DIVU,  32'h0000_0010, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0};
        vecs[5]  = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{"div_7_m2",      OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
        vecs[7]  = '{"div_by_zero",   OP_DIV,   32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[8]  = '{"divu_9_3",      OP_DIVU,  32'h0000_0009, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b0};
        vecs[9]  = '{"div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[10] = '{"divu_max_16",   OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0};
        vecs[11] = '{"divu_5_7",      OP_DIVU,  32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0005, 1'b0};
        vecs[12] = '{"divu_zero_0",   OP_DIVU,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.sr    = '0;
        bus.tg    = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {37'h0, bus.busy, bus.done, bus.div_zero, bus.result1},
              {37'h0, 3'b000, 32'h0});
        check("reset_result2", {40'h0, bus.result2}, 72'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations; also checks result hold and div_zero clear on acceptance.
        prev_r1 = '0;
        prev_r2 = '0;
        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].op, vecs[i].sr, vecs[i].tg);
            if (!vecs[i].dz) begin
                check({vecs[i].name, "_accept"}, {37'h0, bus.busy, bus.div_zero, bus.result1, bus.result2[1:0]},
                      {37'h0, 1'b1, 1'b0, prev_r1, prev_r2[1:0]});
            end
            wait_done(lat, bcnt);
            check({vecs[i].name, "_latency"}, 72'(lat), vecs[i].dz ? 72'd1 : 72'd34);
            check({vecs[i].name, "_busy_cycles"}, 72'(bcnt), vecs[i].dz ? 72'd0 : 72'd33);
            check({vecs[i].name, "_result"}, {7'h0, bus.div_zero, bus.result1, bus.result2},
                  {7'h0, vecs[i].dz, vecs[i].r1, vecs[i].r2});
            @(negedge clk);
            @(negedge clk);
            check({vecs[i].name, "_hold"}, {6'h0, bus.done, bus.div_zero, bus.result1, bus.result2},
                  {6'h0, 1'b0, vecs[i].dz, vecs[i].r1, vecs[i].r2});
            prev_r1 = vecs[i].r1;
            prev_r2 = vecs[i].r2;
        end

        // Start pulsed at cycle 10 of a running multiply is ignored.
        start_op(OP_MULT, 32'h0000_1234, 32'hFFFF_FFFE);
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (lat == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.sr    = 32'h0000_0005;
                bus.tg    = 32'h0000_0005;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("ignored_start_latency", 72'(lat), 72'd34);
        check("ignored_start_result", {8'h0, bus.result1, bus.result2}, {8'h0, 32'hFFFF_DB98, 32'hFFFF_FFFF});
        @(negedge clk);
        @(negedge clk);
        check("ignored_start_no_second_op", {70'h0, bus.busy, bus.done}, 72'h0);

        // Reset at cycle 20 of a multiply aborts it with no done.
        start_op(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (19) @(negedge clk);
        check("pre_reset_busy", {71'h0, bus.busy}, 72'h1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {37'h0, bus.busy, bus.done, bus.div_zero, bus.result1},
              {37'h0, 3'b000, 32'h0});
        check("mid_reset_result2", {40'h0, bus.result2}, 72'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("no_done_after_reset", 72'(done_cnt), 72'd0);

        // First operation after reset release completes normally.
        start_op(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
        wait_done(lat, bcnt);
        check("post_reset_latency", 72'(lat), 72'd34);
        check("post_reset_result", {8'h0, bus.result1, bus.result2}, {8'h0, 32'hFFFE_0001, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
